// File: rtl/aes_arb_pkg.sv
// aes_arb_pkg: shared FSM state type and default sizing for the CCU arbiter
package aes_arb_pkg;
  typedef enum logic [2:0] {IDLE, ACK, RUN, DONE, ABORT} state_t;
  localparam int NUM_CH_DEF  = 4;
  localparam int TIMEOUT_DEF = 1024;
endpackage

// File: rtl/aes_arb_rr_pick.sv
// rr_pick: combinational rotate-priority picker; req/ptr in, valid/idx of first requester at or after ptr out
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 valid,
  output logic [$clog2(N)-1:0] idx
);
  localparam int IW = $clog2(N);
  logic [IW-1:0] k;
  always_comb begin
    valid = |req;
    idx = '0;
    k = '0;
    for (int i = N - 1; i >= 0; i--) begin
      k = IW'((int'(ptr) + i) % N);
      if (req[k]) idx = k;
    end
  end
endmodule

// File: rtl/aes_arb.sv
// aes_arb: round-robin arbiter sharing one CCU among NUM_CH channels (ports: clk, rst, ch_req/ch_e_or_d in, ch_grant/ch_done/ch_err out, eng_enable/eng_e_or_d out, eng_ready in, owner out; optional watchdog via AES_ARB_WATCHDOG_EN)
module aes_arb
  import aes_arb_pkg::*;
#(
  parameter int NUM_CH         = NUM_CH_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         ch_req,
  input  logic [NUM_CH-1:0]         ch_e_or_d,
  output logic [NUM_CH-1:0]         ch_grant,
  output logic [NUM_CH-1:0]         ch_done,
  output logic [NUM_CH-1:0]         ch_err,
  output logic                      eng_enable,
  output logic                      eng_e_or_d,
  input  logic                      eng_ready,
  output logic [$clog2(NUM_CH)-1:0] owner
);
  localparam int IW = $clog2(NUM_CH);
  if (NUM_CH < 2 || NUM_CH > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("aes_arb: unsupported NUM_CH or TIMEOUT_CYCLES");
  end
  state_t state, state_nxt;
  logic [IW-1:0] rr_ptr, pick_idx;
  logic pick_valid, mask_v, active;
  logic [NUM_CH-1:0] owner_oh, req_eff;
  assign owner_oh = NUM_CH'(1) << owner;
  assign active = state == ACK || state == RUN;
  // the channel that just finished sits out one IDLE cycle so it can drop its request
  assign req_eff = mask_v ? ch_req & ~owner_oh : ch_req;
  rr_pick #(.N(NUM_CH)) u_pick (
    .req  (req_eff),
    .ptr  (rr_ptr),
    .valid(pick_valid),
    .idx  (pick_idx)
  );
`ifdef AES_ARB_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] wd_cnt;
  logic wd_hit;
  always_ff @(posedge clk or posedge rst)
    if (rst) wd_cnt <= '0;
    else wd_cnt <= active ? wd_cnt + 1'b1 : '0;
  assign wd_hit = wd_cnt == CW'(TIMEOUT_CYCLES - 1);
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = pick_valid ? ACK : IDLE;
      ACK:     state_nxt = eng_ready ? ACK : RUN;
      RUN:     state_nxt = eng_ready ? DONE : RUN;
      default: state_nxt = IDLE;
    endcase
`ifdef AES_ARB_WATCHDOG_EN
    if (active && wd_hit) state_nxt = ABORT;
`endif
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rr_ptr     <= '0;
      owner      <= '0;
      mask_v     <= 1'b0;
      eng_e_or_d <= 1'b0;
    end else begin
      mask_v <= state == DONE || state == ABORT;
      if (state == IDLE && pick_valid) begin
        owner      <= pick_idx;
        eng_e_or_d <= ch_e_or_d[pick_idx];
      end
      if (state == DONE || state == ABORT) rr_ptr <= owner == IW'(NUM_CH - 1) ? '0 : owner + 1'b1;
    end
  always_comb begin
    eng_enable = active;
    ch_grant = active ? owner_oh : '0;
    ch_done = state == DONE ? owner_oh : '0;
`ifdef AES_ARB_WATCHDOG_EN
    ch_err = state == ABORT ? owner_oh : '0;
`else
    ch_err = '0;
`endif
  end
endmodule
